rc5_stream_core: RTL and testbench
==================================

// Module: rc5_stream_core
// PURPOSE
//  Parametrised RC5-W/R/B block cipher engine: next generation of rc5 core. Generic word size, key
//  length and max rounds; per-block encrypt/decrypt select; valid/ready stream handshake on in/out.
//  Sits between host register/DMA front-end and data path; one block in flight, one round per clk.
// PARAMETERS
//  W          32   word size in bits (16, 32 or 64); block = 2*W bits
//  KEY_BYTES  16   secret key length b in bytes (1..255)
//  MAX_ROUNDS 20   largest supported round count; sizes S table (2*MAX_ROUNDS+2 words)
// PORTS
//  clk         in   1              clock, all logic rising-edge
//  rst         in   1              synchronous reset, active high
//  num_rounds  in   RW             rounds r, RW=$clog2(MAX_ROUNDS+1); sampled on load_key
//  key         in   8*KEY_BYTES    secret key, byte k = key[8k+7:8k]; sampled on load_key
//  load_key    in   1              1-cycle strobe: start key expansion
//  key_ready   out  1              S table valid for sampled key/rounds
//  in_valid    in   1              d_in/in_decrypt valid
//  in_ready    out  1              engine can accept a block
//  in_decrypt  in   1              0 = encrypt, 1 = decrypt this block
//  d_in        in   2*W            block {B,A}, A = d_in[W-1:0]
//  out_valid   out  1              d_out valid; held until out_ready
//  out_ready   in   1              consumer accepts d_out
//  d_out       out  2*W            result {B,A}
// BEHAVIOUR
//  Reset: key_ready=0, in_ready=0, out_valid=0, d_out=0, state=IDLE_NOKEY; S/L contents don't-care.
//  States: IDLE_NOKEY -> KINIT -> KMIX -> IDLE -> (WHITEN -> ROUND) -> OUT -> IDLE.
//  load_key: sample key, r=min(num_rounds,MAX_ROUNDS), t=2(r+1), c=max(1,ceil(KEY_BYTES*8/W)).
//   Also loads L[0..c-1] from key bytes little-endian. Legal in any state; aborts block in flight
//   (dropped, no out_valid) and clears a pending out_valid. key_ready=0 from next cycle.
//  KINIT: t cycles, S[0]=P_W, S[i]=S[i-1]+Q_W. KMIX: 3*max(t,c) cycles, one step/cycle:
//   A=S[i]=(S[i]+A+B)<<<3; B=L[j]=(L[j]+A+B)<<<(A+B); i=(i+1)%t, j=(j+1)%c; A,B start 0.
//  key_ready rises exactly t+3*max(t,c) cycles after the load_key edge, then stays high.
//  in_ready = key_ready & state==IDLE (combinational from state). Accept on in_valid&in_ready.
//  Encrypt: WHITEN A+=S[0], B+=S[1]; round i=1..r: A=((A^B)<<<B)+S[2i]; B=((B^A)<<<A)+S[2i+1].
//  Decrypt: round i=r..1: B=((B-S[2i+1])>>>A)^A; A=((A-S[2i])>>>B)^B; final B-=S[1], A-=S[0].
//  All arithmetic mod 2^W; rotate amount = low $clog2(W) bits of operand.
//  Latency: 1 whitening cycle + r round cycles; out_valid rises r+1 cycles after accept edge
//   (decrypt: r rounds then final unwhiten cycle, same latency). r=0 -> whitening only, latency 1.
//  OUT: d_out, out_valid stable until out_valid&out_ready; in_ready returns high next cycle.
//  in_valid while in_ready=0: ignored, no state change. load_key and in_valid same cycle: load wins.
//  rst mid-operation: all of above reset; key must be reloaded.
//  num_rounds change without load_key: no effect.
// STRUCTURE
//  rc5_pkg: functions p_const(W), q_const(W) (B7E1/9E37, B7E15163/9E3779B9,
//   B7E151628AED2A6B/9E3779B97F4A7C15), rol/ror functions, state enum rc5_state_e.
//  Sub-module rc5_key_sched: owns S/L register arrays, KINIT/KMIX sequencing, key_ready;
//   exposes two combinational S read ports (index 2i, 2i+1) to the round datapath in this module.
// TESTING
//  1 W=32,r=12,key=0, enc d_in=0 -> d_out=64'h6D8F4B15_EEDBA521; key_ready after 26+78 cycles.
//  2 Same key, dec 64'h6D8F4B15_EEDBA521 -> 64'h0; out_valid exactly 13 cycles after accept.
//  3 Random keys/data, r in {0,1,12,MAX_ROUNDS}, W in {16,32,64} -> dec(enc(x))==x, vs C model.
//  4 out_ready held low 10 cycles -> d_out stable, in_ready=0, in_valid ignored; then drains.
//  5 load_key during ROUND -> no out_valid for that block; after new key, enc matches model.
//  6 rst asserted in KMIX -> key_ready/in_ready/out_valid=0 next cycle; in_valid ignored.

Source files
------------

// File: rtl/rc5_pkg.sv
// Shared types and helpers for the RC5 stream core: magic constants, width-generic rotates,
// and the engine state encoding.
package rc5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE_NOKEY,
    ST_KINIT,
    ST_KMIX,
    ST_IDLE,
    ST_WHITEN,
    ST_ROUND,
    ST_OUT
  } rc5_state_e;

  function automatic logic [63:0] p_const(input int w);
    case (w)
      16:      return 64'h0000_0000_0000_B7E1;
      64:      return 64'hB7E1_5162_8AED_2A6B;
      default: return 64'h0000_0000_B7E1_5163;
    endcase
  endfunction

  function automatic logic [63:0] q_const(input int w);
    case (w)
      16:      return 64'h0000_0000_0000_9E37;
      64:      return 64'h9E37_79B9_7F4A_7C15;
      default: return 64'h0000_0000_9E37_79B9;
    endcase
  endfunction

  // Rotates act on the low w bits of x; only the low log2(w) bits of amt matter.
  function automatic logic [63:0] rol(input logic [63:0] x, input logic [5:0] amt, input int w);
    logic [63:0] m, xv;
    logic [6:0]  s, rs;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = {1'b0, amt} & 7'(w - 1);
    rs = 7'(w) - s;
    xv = x & m;
    return ((xv << s) | (xv >> rs)) & m;
  endfunction

  function automatic logic [63:0] ror(input logic [63:0] x, input logic [5:0] amt, input int w);
    logic [63:0] m, xv;
    logic [6:0]  s, rs;
    m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    s  = {1'b0, amt} & 7'(w - 1);
    rs = 7'(w) - s;
    xv = x & m;
    return ((xv >> s) | (xv << rs)) & m;
  endfunction

endpackage

// File: rtl/rc5_key_sched.sv
// RC5 key schedule: holds the S and L tables, runs KINIT/KMIX one step per clock and
// serves the two round-key read ports used by the block datapath.
module rc5_key_sched
  import rc5_pkg::*;
#(
  parameter int  W          = 32,
  parameter int  KEY_BYTES  = 16,
  parameter int  MAX_ROUNDS = 20,
  localparam int RW         = $clog2(MAX_ROUNDS + 1),
  localparam int SW         = $clog2(2 * MAX_ROUNDS + 2)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_key,
  input  logic [RW-1:0]          num_rounds,
  input  logic [8*KEY_BYTES-1:0] key,
  input  rc5_state_e             state,
  input  logic [RW-1:0]          s_idx,
  output logic [RW-1:0]          rounds,
  output logic                   phase_last,
  output logic                   key_ready,
  output logic [W-1:0]           s_even,
  output logic [W-1:0]           s_odd
);

  localparam int T_MAX = 2 * MAX_ROUNDS + 2;
  localparam int C     = (KEY_BYTES * 8 + W - 1) / W;
  localparam int LW    = (C > 1) ? $clog2(C) : 1;
  localparam int N_MAX = 3 * ((T_MAX > C) ? T_MAX : C);
  localparam int NW    = $clog2(N_MAX + 1);
  localparam int KPW   = C * W;
  localparam logic [63:0] P64 = p_const(W);
  localparam logic [63:0] Q64 = q_const(W);

  logic [W-1:0]   s_tab [T_MAX];
  logic [W-1:0]   l_tab [C];
  logic [SW-1:0]  i_idx, t_last;
  logic [LW-1:0]  j_idx;
  logic [NW-1:0]  cnt, n_last, t_new, m_new;
  logic [RW-1:0]  r_clamp;
  logic [W-1:0]   kacc, ma, mb, mix_a, mix_b;
  logic [KPW-1:0] key_pad;

  function automatic logic [W-1:0] rolw(input logic [W-1:0] x, input logic [W-1:0] s);
    logic [63:0] r;
    r = rol(64'(x), s[5:0], W);
    return r[W-1:0];
  endfunction

  assign r_clamp = (num_rounds > RW'(MAX_ROUNDS)) ? RW'(MAX_ROUNDS) : num_rounds;
  assign t_new   = (NW'(r_clamp) + NW'(1)) << 1;
  assign m_new   = (t_new > NW'(C)) ? t_new : NW'(C);
  assign key_pad = KPW'(key);

  assign mix_a = rolw(s_tab[i_idx] + ma + mb, W'(3));
  assign mix_b = rolw(l_tab[j_idx] + mix_a + mb, mix_a + mb);

  assign s_even     = s_tab[{s_idx, 1'b0}];
  assign s_odd      = s_tab[{s_idx, 1'b1}];
  assign phase_last = (state == ST_KINIT && i_idx == t_last) ||
                      (state == ST_KMIX && cnt == n_last);

  // NOTE: the S/L tables carry no reset; their contents are meaningless until a key is loaded,
  // and leaving them unreset lets them map onto plain register files or RAM.
  always_ff @(posedge clk) begin
    if (load_key) begin
      for (int k = 0; k < C; k++) l_tab[k] <= key_pad[k*W +: W];
    end else if (state == ST_KINIT) begin
      s_tab[i_idx] <= kacc;
    end else if (state == ST_KMIX) begin
      s_tab[i_idx] <= mix_a;
      l_tab[j_idx] <= mix_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rounds    <= '0;
      t_last    <= '0;
      n_last    <= '0;
      i_idx     <= '0;
      j_idx     <= '0;
      cnt       <= '0;
      kacc      <= '0;
      ma        <= '0;
      mb        <= '0;
      key_ready <= 1'b0;
    end else if (load_key) begin
      rounds    <= r_clamp;
      t_last    <= SW'(t_new - NW'(1));
      n_last    <= m_new + (m_new << 1) - NW'(1);
      i_idx     <= '0;
      j_idx     <= '0;
      cnt       <= '0;
      kacc      <= P64[W-1:0];
      ma        <= '0;
      mb        <= '0;
      key_ready <= 1'b0;
    end else begin
      case (state)
        ST_KINIT: begin
          kacc  <= kacc + Q64[W-1:0];
          i_idx <= (i_idx == t_last) ? '0 : i_idx + SW'(1);
        end
        ST_KMIX: begin
          ma    <= mix_a;
          mb    <= mix_b;
          i_idx <= (i_idx == t_last) ? '0 : i_idx + SW'(1);
          j_idx <= (j_idx == LW'(C - 1)) ? '0 : j_idx + LW'(1);
          cnt   <= cnt + NW'(1);
          if (cnt == n_last) key_ready <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rc5_stream_core.sv
// RC5-W/R/B stream engine: valid/ready block interface, one block in flight, one round per clock,
// per-block encrypt/decrypt; round keys come from rc5_key_sched.
module rc5_stream_core
  import rc5_pkg::*;
#(
  parameter int  W          = 32,
  parameter int  KEY_BYTES  = 16,
  parameter int  MAX_ROUNDS = 20,
  localparam int RW         = $clog2(MAX_ROUNDS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [RW-1:0]          num_rounds,
  input  logic [8*KEY_BYTES-1:0] key,
  input  logic                   load_key,
  output logic                   key_ready,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_decrypt,
  input  logic [2*W-1:0]         d_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*W-1:0]         d_out
);

  rc5_state_e    state, state_nxt;
  logic [W-1:0]  a, b, s_even, s_odd;
  logic [W-1:0]  enc_a, enc_b, dec_a, dec_b;
  logic [RW-1:0] rnd, rounds, s_idx;
  logic          dec, phase_last, accept;

  function automatic logic [W-1:0] rolw(input logic [W-1:0] x, input logic [W-1:0] s);
    logic [63:0] r;
    r = rol(64'(x), s[5:0], W);
    return r[W-1:0];
  endfunction

  function automatic logic [W-1:0] rorw(input logic [W-1:0] x, input logic [W-1:0] s);
    logic [63:0] r;
    r = ror(64'(x), s[5:0], W);
    return r[W-1:0];
  endfunction

  rc5_key_sched #(.W(W), .KEY_BYTES(KEY_BYTES), .MAX_ROUNDS(MAX_ROUNDS)) u_key_sched (
    .clk        (clk),
    .rst        (rst),
    .load_key   (load_key),
    .num_rounds (num_rounds),
    .key        (key),
    .state      (state),
    .s_idx      (s_idx),
    .rounds     (rounds),
    .phase_last (phase_last),
    .key_ready  (key_ready),
    .s_even     (s_even),
    .s_odd      (s_odd)
  );

  assign s_idx  = (state == ST_WHITEN) ? '0 : rnd;
  assign accept = in_valid && in_ready;
  assign d_out  = {b, a};

  assign enc_a = rolw(a ^ b, b) + s_even;
  assign enc_b = rolw(b ^ enc_a, enc_a) + s_odd;
  assign dec_b = rorw(b - s_odd, a) ^ a;
  assign dec_a = rorw(a - s_even, dec_b) ^ dec_b;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE_NOKEY;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_KINIT: if (phase_last) state_nxt = ST_KMIX;
      ST_KMIX:  if (phase_last) state_nxt = ST_IDLE;
      ST_IDLE: begin
        in_ready = key_ready;
        if (in_valid && key_ready)
          state_nxt = (in_decrypt && rounds != '0) ? ST_ROUND : ST_WHITEN;
      end
      ST_WHITEN: state_nxt = (dec || rounds == '0) ? ST_OUT : ST_ROUND;
      ST_ROUND: begin
        if (dec && rnd == RW'(1))     state_nxt = ST_WHITEN;
        else if (!dec && rnd == rounds) state_nxt = ST_OUT;
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: ;
    endcase
    // A new key overrides everything, including a block in flight or awaiting drain.
    if (load_key) state_nxt = ST_KINIT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a   <= '0;
      b   <= '0;
      rnd <= '0;
      dec <= 1'b0;
    end else if (!load_key) begin
      case (state)
        ST_IDLE: if (accept) begin
          a   <= d_in[W-1:0];
          b   <= d_in[2*W-1:W];
          dec <= in_decrypt;
          rnd <= in_decrypt ? rounds : RW'(1);
        end
        ST_WHITEN: begin
          a <= dec ? a - s_even : a + s_even;
          b <= dec ? b - s_odd  : b + s_odd;
        end
        ST_ROUND: begin
          a   <= dec ? dec_a : enc_a;
          b   <= dec ? dec_b : enc_b;
          rnd <= dec ? rnd - RW'(1) : rnd + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc5_stream_core.sv
// Directed bench for rc5_stream_core (W=32, 16-byte key): published RC5-32/12/16 vectors,
// round trips, latency, back-pressure, key reload abort and reset during key mixing.
module tb_rc5_stream_core;

  localparam int W  = 32;
  localparam int KB = 16;
  localparam int MR = 20;
  localparam int RW = $clog2(MR + 1);

  localparam logic [127:0] K0 = 128'h0;
  localparam logic [127:0] K1 = 128'h91CEA91001A5556351B241BE19465F91;
  localparam logic [63:0]  V0 = 64'h0;
  localparam logic [63:0]  C0 = 64'h6D8F4B15_EEDBA521;
  localparam logic [63:0]  C1 = 64'h52892B5B_AC13C0F7;
  localparam logic [63:0]  X0 = 64'h01234567_89ABCDEF;

  logic            clk = 1'b0;
  logic            rst;
  logic [RW-1:0]   num_rounds;
  logic [8*KB-1:0] key;
  logic            load_key;
  logic            key_ready;
  logic            in_valid;
  logic            in_ready;
  logic            in_decrypt;
  logic [2*W-1:0]  d_in;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  d_out;

  int passed = 0;
  int total  = 0;

  rc5_stream_core #(.W(W), .KEY_BYTES(KB), .MAX_ROUNDS(MR)) dut (
    .clk        (clk),
    .rst        (rst),
    .num_rounds (num_rounds),
    .key        (key),
    .load_key   (load_key),
    .key_ready  (key_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_decrypt (in_decrypt),
    .d_in       (d_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .d_out      (d_out)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [127:0] k, input logic [RW-1:0] r, input logic in_v,
                         input int exp_cyc, input string tag);
    int cyc;
    bit ov;
    key        = k;
    num_rounds = r;
    load_key   = 1'b1;
    in_valid   = in_v;
    in_decrypt = 1'b0;
    d_in       = X0;
    tick();
    load_key = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_kr_drop"}, key_ready, 0);
    cyc = 0;
    ov  = 1'b0;
    while (!key_ready && cyc < 1000) begin
      tick();
      cyc++;
      if (out_valid) ov = 1'b1;
    end
    chk({tag, "_key_latency"}, cyc, exp_cyc);
    chk({tag, "_no_out"}, ov, 0);
  endtask

  task automatic run_block(input logic dec, input logic [63:0] din,
                           output logic [63:0] dout, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick();
      n++;
    end
    in_valid   = 1'b1;
    in_decrypt = dec;
    d_in       = din;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    dout      = d_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] res, res2;
    int          lat, n;

    rst        = 1'b1;
    num_rounds = RW'(12);
    key        = '0;
    load_key   = 1'b0;
    in_valid   = 1'b0;
    in_decrypt = 1'b0;
    d_in       = '0;
    out_ready  = 1'b0;
    tick();
    tick();
    chk("rst_key_ready", key_ready, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_d_out", d_out, 0);
    rst = 1'b0;
    tick();

    // Zero key, 12 rounds: t=26, c=4 -> 26 + 78 cycles of expansion.
    do_load(K0, RW'(12), 1'b0, 104, "k0");
    chk("k0_in_ready", in_ready, 1);
    run_block(1'b0, V0, res, lat);
    chk("k0_enc", res, C0);
    chk("k0_enc_lat", lat, 13);
    chk("k0_in_ready_after", in_ready, 1);
    run_block(1'b1, C0, res, lat);
    chk("k0_dec", res, V0);
    chk("k0_dec_lat", lat, 13);

    // Second published vector; reload while a key is already valid.
    do_load(K1, RW'(12), 1'b0, 104, "k1");
    run_block(1'b0, C0, res, lat);
    chk("k1_enc", res, C1);
    chk("k1_enc_lat", lat, 13);
    run_block(1'b1, C1, res, lat);
    chk("k1_dec", res, C0);

    // Back-pressure: result held, further blocks ignored until drained.
    in_valid   = 1'b1;
    in_decrypt = 1'b0;
    d_in       = C0;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("hold_first", d_out, C1);
    for (int k = 0; k < 10; k++) begin
      in_valid   = 1'b1;
      in_decrypt = 1'b1;
      d_in       = V0;
      tick();
      chk("hold_d_out", d_out, C1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_out_valid", out_valid, 1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
    tick();
    chk("drain_no_stale", out_valid, 0);

    // Key reload mid-round drops the block in flight.
    in_valid   = 1'b1;
    in_decrypt = 1'b0;
    d_in       = C0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    chk("abort_pre_out", out_valid, 0);
    do_load(K0, RW'(12), 1'b0, 104, "abort");
    run_block(1'b0, V0, res, lat);
    chk("abort_enc", res, C0);

    // Changing num_rounds without a reload has no effect.
    num_rounds = RW'(3);
    run_block(1'b0, V0, res, lat);
    chk("nr_change_enc", res, C0);
    chk("nr_change_lat", lat, 13);

    // load_key with in_valid in the same cycle: load wins. r=0: t=2, c=4 -> 2 + 12 cycles.
    do_load(K1, RW'(0), 1'b1, 14, "samecyc");
    run_block(1'b0, X0, res, lat);
    chk("r0_enc_lat", lat, 1);
    run_block(1'b1, res, res2, lat);
    chk("r0_roundtrip", res2, X0);
    chk("r0_dec_lat", lat, 1);

    // Over-range round count clamps to MAX_ROUNDS: t=42 -> 42 + 126 cycles.
    do_load(K1, RW'(31), 1'b0, 168, "clamp");
    run_block(1'b0, X0, res, lat);
    chk("clamp_enc_lat", lat, 21);
    run_block(1'b1, res, res2, lat);
    chk("clamp_roundtrip", res2, X0);
    chk("clamp_dec_lat", lat, 21);

    // Reset during key mixing.
    key        = K0;
    num_rounds = RW'(12);
    load_key   = 1'b1;
    tick();
    load_key = 1'b0;
    repeat (40) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    d_in     = V0;
    tick();
    chk("rst_kmix_key_ready", key_ready, 0);
    chk("rst_kmix_in_ready", in_ready, 0);
    chk("rst_kmix_out_valid", out_valid, 0);
    rst = 1'b0;
    repeat (120) tick();
    chk("post_rst_key_ready", key_ready, 0);
    chk("post_rst_in_ready", in_ready, 0);
    chk("post_rst_out_valid", out_valid, 0);
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
